uart_word_packer: RTL

UART_WORD_PACKER -- requirements
Module: uart_word_packer

---
 rtl/rsa_uart_pkg.sv | 16 +
 rtl/inter_byte_timer.sv | 31 +++
 rtl/uart_word_packer.sv | 110 +++++++++++
 3 files changed

// File: rtl/rsa_uart_pkg.sv
// Shared constants and FSM encoding for the UART receive path feeding the RSA core.
package rsa_uart_pkg;

    localparam int OVERSAMPLE        = 16;
    localparam int FRAME_BITS        = 10;
    localparam int NBYTES_DEF        = 4;
    // Two full frames of silence at the oversampling rate.
    localparam int TIMEOUT_TICKS_DEF = 2 * FRAME_BITS * OVERSAMPLE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } pk_state_e;

endpackage

// File: rtl/inter_byte_timer.sv
// Counts s_tick pulses since the last accepted byte; saturates at the limit.
module inter_byte_timer
    import rsa_uart_pkg::*;
#(
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic s_tick,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_TICKS);

    logic [TW-1:0] cnt;

    // Clear has priority so a byte arriving with a tick never times out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (s_tick && cnt != LIMIT)
            cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/uart_word_packer.sv
// Packs received UART bytes big-endian into NBYTES-wide words with a valid/ready hold stage.
module uart_word_packer
    import rsa_uart_pkg::*;
#(
    parameter int NBYTES        = NBYTES_DEF,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_tick,
    input  logic [7:0]          din,
    input  logic                rx_done_tick,
    output logic [8*NBYTES-1:0] word,
    output logic                word_valid,
    input  logic                word_ready,
    output logic                overrun,
    output logic                timeout_err
);

    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES + 1);
    localparam logic [CW-1:0] FULL = CW'(NBYTES);
    localparam pk_state_e FIRST_NEXT = (NBYTES == 1) ? HOLD : COLLECT;

    pk_state_e     state, state_n;
    logic [W-1:0]  word_n;
    logic [CW-1:0] count, count_n;
    logic          overrun_n, timeout_n;
    logic          tmr_clear, tmr_expired;

    inter_byte_timer #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .s_tick (s_tick),
        .expired(tmr_expired)
    );

    always_comb begin
        state_n   = state;
        word_n    = word;
        count_n   = count;
        overrun_n = 1'b0;
        timeout_n = 1'b0;
        tmr_clear = 1'b1;
        case (state)
            IDLE: begin
                if (rx_done_tick) begin
                    word_n      = '0;
                    word_n[7:0] = din;
                    count_n     = CW'(1);
                    state_n     = FIRST_NEXT;
                end
            end
            COLLECT: begin
                tmr_clear = rx_done_tick;
                if (rx_done_tick) begin
                    word_n      = word << 8;
                    word_n[7:0] = din;
                    count_n     = count + 1'b1;
                    if (count_n == FULL)
                        state_n = HOLD;
                end else if (tmr_expired) begin
                    word_n    = '0;
                    count_n   = '0;
                    state_n   = IDLE;
                    timeout_n = 1'b1;
                end
            end
            HOLD: begin
                if (word_ready) begin
                    // A byte landing on the handshake cycle starts the next word.
                    if (rx_done_tick) begin
                        word_n      = '0;
                        word_n[7:0] = din;
                        count_n     = CW'(1);
                        state_n     = FIRST_NEXT;
                    end else begin
                        count_n = '0;
                        state_n = IDLE;
                    end
                end else if (rx_done_tick) begin
                    overrun_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            word        <= '0;
            count       <= '0;
            word_valid  <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            word        <= word_n;
            count       <= count_n;
            word_valid  <= (state_n == HOLD);
            overrun     <= overrun_n;
            timeout_err <= timeout_n;
        end
    end

endmodule
